lfsr_chan_sched: RTL and testbench

Time-multiplexes one 31-bit, 8-bit-per-cycle Fibonacci LFSR scrambler step among NUM_CH independent byte streams. Each channel keeps its own LFSR state in a register bank. A round-robin arbiter grants at most one channel per cycle onto the shared step logic. Results go to a single registered output port with valid/ready backpressure. The block sits between per-lane byte sources and the downstream serializer, so per-lane scramblers can be removed.

---
 rtl/lfsr_chan_sched_if.sv | 43 ++++
 rtl/lfsr_chan_sched.sv | 116 +++++++++++
 tb/tb_lfsr_chan_sched.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_chan_sched_if.sv
// lfsr_chan_sched_if
//   Bundles the request, seed and result signals of lfsr_chan_sched.
//   master: the surrounding logic (byte sources, seed controller, serializer).
//   slave : the scheduler itself.
//
//   req_valid  [NUM_CH]     channel i has a byte to scramble
//   req_data   [8*NUM_CH]   byte of channel i at [8*i+7:8*i]
//   req_ready  [NUM_CH]     one-hot or zero, byte of channel i taken on valid&ready
//   seed_load  [NUM_CH]     one-cycle pulse, overwrite state of channel i
//   seed_value [31]         seed shared by all channels loading this cycle
//   out_valid  [1]          out_data / out_ch hold a result
//   out_data   [8]          scrambled byte
//   out_ch     [CH_W]       channel that produced out_data
//   out_ready  [1]          downstream takes the result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a valid producer holds its payload stable until that edge, and
// ready may depend combinationally on the other side's valid.
interface lfsr_chan_sched_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]   req_valid;
  logic [8*NUM_CH-1:0] req_data;
  logic [NUM_CH-1:0]   req_ready;
  logic [NUM_CH-1:0]   seed_load;
  logic [30:0]         seed_value;
  logic                out_valid;
  logic [7:0]          out_data;
  logic [CH_W-1:0]     out_ch;
  logic                out_ready;

  modport master (
    output req_valid, req_data, seed_load, seed_value, out_ready,
    input  req_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  req_valid, req_data, seed_load, seed_value, out_ready,
    output req_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/lfsr_chan_sched.sv
// lfsr_chan_sched
//   Shares one 8-bit-per-cycle Fibonacci LFSR scrambler step (x^31+x^28+1)
//   among NUM_CH byte streams. Each channel keeps its own 31-bit state; a
//   round-robin arbiter puts at most one channel per cycle through the step
//   and the result lands in a single registered output with valid/ready.
//
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of lfsr_chan_sched_if (requests, seeds, result)
module lfsr_chan_sched #(
  parameter int          NUM_CH   = 4,
  parameter logic [30:0] RST_SEED = 31'h7FFFFFFF
) (
  input logic             clk,
  input logic             rst,
  lfsr_chan_sched_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [30:0]     state [NUM_CH];
  logic [CH_W-1:0] rr_ptr;
  logic            out_valid_q;
  logic [7:0]      out_data_q;
  logic [CH_W-1:0] out_ch_q;

  logic            out_free;
  logic [NUM_CH-1:0] eligible;
  logic            grant_hit;
  logic [CH_W-1:0] grant_ch;
  logic [CH_W-1:0] rr_next;
  logic [7:0]      step_d;
  logic [7:0]      step_o;
  logic [30:0]     step_s;
  logic            fb;
  logic [30:0]     seed_fix;
  int              idx;

  assign out_free = !out_valid_q || bus.out_ready;
  // A channel loading a seed this cycle must not also step its old state.
  assign eligible = bus.req_valid & ~bus.seed_load;

  // Round-robin search starting at rr_ptr; held off during reset so no
  // handshake is advertised while the registers are cleared.
  always_comb begin
    grant_hit = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    if (out_free && !rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!grant_hit && eligible[idx]) begin
          grant_hit = 1'b1;
          grant_ch  = CH_W'(idx);
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_hit) bus.req_ready[grant_ch] = 1'b1;
  end

  // Shared scrambler step: eight serial LFSR steps unrolled, LSB first.
  always_comb begin
    step_d = bus.req_data[int'(grant_ch)*8 +: 8];
    step_s = state[grant_ch];
    step_o = '0;
    fb     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb        = step_s[30] ^ step_s[27];
      step_o[i] = step_d[i] ^ fb;
      step_s    = {step_s[29:0], fb};
    end
  end

  // An all-zero state would lock the LFSR, so a zero seed loads all ones.
  assign seed_fix = (bus.seed_value == '0) ? 31'h7FFFFFFF : bus.seed_value;

  assign rr_next = (int'(grant_ch) >= NUM_CH - 1) ? '0 : grant_ch + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) state[i] <= RST_SEED;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.seed_load[i])
          state[i] <= seed_fix;
        else if (grant_hit && grant_ch == CH_W'(i))
          state[i] <= step_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (grant_hit) begin
      rr_ptr      <= rr_next;
      out_valid_q <= 1'b1;
      out_data_q  <= step_o;
      out_ch_q    <= grant_ch;
    end else if (out_free) begin
      // Payload is left as-is; only the valid flag drops.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_lfsr_chan_sched.sv
// tb_lfsr_chan_sched
//   Drives lfsr_chan_sched through directed scenarios and a random phase.
//   A cycle-level reference model predicts grants and scrambled bytes and
//   pushes them into a queue; a separate monitor pops and compares on every
//   output handshake.
module tb_lfsr_chan_sched;
  localparam int          NUM_CH   = 4;
  localparam int          CH_W     = 2;
  localparam logic [30:0] RST_SEED = 31'h7FFFFFFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_chan_sched_if #(.NUM_CH(NUM_CH)) bus ();

  lfsr_chan_sched #(.NUM_CH(NUM_CH), .RST_SEED(RST_SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [CH_W+7:0] exp_q[$];

  // reference model
  logic [30:0]       m_state [NUM_CH];
  int                m_rr;
  logic              cur_valid;
  logic              nxt_valid;
  logic [NUM_CH-1:0] exp_ready;
  bit                mon_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The scrambler defined as a bit stream: each output bit is the data bit
  // XOR the LFSR feedback, and the history of feedback bits forms the state.
  function automatic logic [38:0] ref_step(input logic [30:0] s, input logic [7:0] d);
    logic hist [$];
    logic [7:0] o;
    logic [30:0] ns;
    for (int b = 30; b >= 0; b--) hist.push_back(s[b]);  // hist[0] = oldest bit
    for (int i = 0; i < 8; i++) begin
      logic f;
      f = hist[0] ^ hist[3];
      o[i] = d[i] ^ f;
      void'(hist.pop_front());
      hist.push_back(f);
    end
    for (int b = 0; b < 31; b++) ns[30-b] = hist[b];
    return {ns, o};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) m_state[i] = RST_SEED;
    m_rr      = 0;
    cur_valid = 1'b0;
    nxt_valid = 1'b0;
    exp_ready = '0;
  endtask

  task automatic drive_idle();
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.seed_load  = '0;
    bus.seed_value = '0;
    bus.out_ready  = 1'b1;
  endtask

  // driver: one cycle of stimulus plus the model's prediction for the edge
  task automatic drive_cycle(input logic [NUM_CH-1:0] v, input logic [8*NUM_CH-1:0] d,
                             input logic [NUM_CH-1:0] ld, input logic [30:0] sv,
                             input logic ordy);
    logic free;
    int grant;
    logic [38:0] r;
    @(posedge clk);
    #1;
    cur_valid      = nxt_valid;
    bus.req_valid  = v;
    bus.req_data   = d;
    bus.seed_load  = ld;
    bus.seed_value = sv;
    bus.out_ready  = ordy;
    free      = !cur_valid || ordy;
    grant     = -1;
    exp_ready = '0;
    if (free) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_rr + k) % NUM_CH;
        if (grant < 0 && v[c] && !ld[c]) grant = c;
      end
    end
    if (grant >= 0) begin
      r = ref_step(m_state[grant], d[8*grant +: 8]);
      exp_ready[grant] = 1'b1;
      exp_q.push_back({CH_W'(grant), r[7:0]});
      m_state[grant] = r[38:8];
      m_rr      = (grant + 1) % NUM_CH;
      nxt_valid = 1'b1;
    end else if (free) begin
      nxt_valid = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++)
      if (ld[i]) m_state[i] = (sv == 31'd0) ? 31'h7FFFFFFF : sv;
    mon_en = 1'b1;
  endtask

  // monitor
  logic            held;
  logic [CH_W+7:0] hold_val;
  initial begin
    held = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("out_valid", 64'(bus.out_valid), 64'(cur_valid));
        if (held) check("hold_stable", 64'({bus.out_ch, bus.out_data}), 64'(hold_val));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got ch %0d data %0h expected nothing", bus.out_ch, bus.out_data);
          end else begin
            logic [CH_W+7:0] e;
            e = exp_q.pop_front();
            check("out_ch", 64'(bus.out_ch), 64'(e[CH_W+7:8]));
            check("out_data", 64'(bus.out_data), 64'(e[7:0]));
          end
          held = 1'b0;
        end else if (bus.out_valid) begin
          held = 1'b1;
          hold_val = {bus.out_ch, bus.out_data};
        end else begin
          held = 1'b0;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    logic [8*NUM_CH-1:0] rd;
    mon_en = 1'b0;
    model_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_ch", 64'(bus.out_ch), 64'd0);
    bus.req_valid = '1;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    rst = 1'b0;

    // reset seed: channel 0 sends 0xA5
    drive_cycle(4'b0001, 32'h000000A5, '0, '0, 1'b1);
    drive_cycle('0, '0, '0, '0, 1'b1);
    check("state0_after_a5", 64'(dut.state[0]), 64'h7FFFFF00);

    // seed load on channel 2, then channel 2 sends 0x00 -> 0x01
    drive_cycle('0, '0, 4'b0100, 31'h40000000, 1'b1);
    drive_cycle(4'b0100, 32'h00000000, '0, '0, 1'b1);
    drive_cycle('0, '0, '0, '0, 1'b1);
    check("state2_after_seed", 64'(dut.state[2]), 64'h00000080);
    drive_cycle('0, '0, 4'b0100, 31'd0, 1'b1);
    drive_cycle('0, '0, '0, '0, 1'b1);
    check("state2_zero_seed", 64'(dut.state[2]), 64'h7FFFFFFF);

    // round-robin: all channels request continuously
    for (int i = 0; i < 6; i++) drive_cycle('1, $urandom, '0, '0, 1'b1);

    // backpressure: 5 cycles of out_ready low with requests pending
    for (int i = 0; i < 5; i++) drive_cycle('1, $urandom, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle('1, $urandom, '0, '0, 1'b1);
    drive_cycle('0, '0, '0, '0, 1'b1);

    // collision: get rr pointer to 1, then load channel 1 while all request
    drive_cycle(4'b0001, $urandom, '0, '0, 1'b1);
    drive_cycle('1, $urandom, 4'b0010, 31'h40000000, 1'b1);
    drive_cycle(4'b0010, 32'h00000000, '0, '0, 1'b1);
    drive_cycle('0, '0, '0, '0, 1'b1);
    check("state1_collision", 64'(dut.state[1]), 64'h00000080);

    // random phase
    for (int i = 0; i < 300; i++) begin
      rd = {$urandom, $urandom} >> 32;
      drive_cycle(4'($urandom), rd,
                  ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0,
                  ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom),
                  $urandom_range(0, 3) != 0);
    end

    // async reset mid-burst
    for (int i = 0; i < 3; i++) drive_cycle('1, $urandom, '0, '0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    mon_en = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    model_reset();
    drive_idle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) check("midrst_state", 64'(dut.state[i]), 64'(RST_SEED));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive_cycle('1, $urandom, '0, '0, 1'b1);

    // drain
    for (int i = 0; i < 4; i++) drive_cycle('0, '0, '0, '0, 1'b1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
